// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch unit with a small in-order instruction queue
//
// Fetches sequential words from instruction memory (one outstanding request),
// buffers {pc, instruction} pairs and presents the oldest to decode.
// A redirect flushes the queue and restarts fetch at the new target; a request
// already on the bus when the redirect arrives is completed and its word dropped.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   imem_req/imem_addr       fetch request and word-aligned address
//   imem_ack/imem_rdata      fetch completion and returned word
//   redirect/redirect_pc     taken branch/jump and its target
//   dec_valid/dec_ready      head-of-queue handshake with decode
//   dec_inst/dec_pc          head instruction and its address (0 when empty)
//   count                    queue occupancy
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [31:0]              dec_inst,
    output logic [31:0]              dec_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_SQUASH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    // Address of the request left on the bus when a redirect arrived before its ack.
    logic [31:0]     squash_addr_q, squash_addr_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     ent_pc_q   [DEPTH];
    logic [31:0]     ent_inst_q [DEPTH];

    logic            push;
    logic            pop;
    logic            unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign imem_req  = (state_q != S_IDLE);
    assign imem_addr = (state_q == S_SQUASH) ? squash_addr_q : fetch_pc_q;
    assign dec_valid = (count_q != '0) && !redirect;
    assign dec_inst  = (count_q != '0) ? ent_inst_q[head_q] : 32'h0;
    assign dec_pc    = (count_q != '0) ? ent_pc_q[head_q]   : 32'h0;
    assign count     = count_q;
    // A redirect already forces dec_valid low, so it also suppresses the pop.
    assign pop       = dec_valid && dec_ready;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        squash_addr_d = squash_addr_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        push          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (redirect || (count_q < CW'(DEPTH))) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect) begin
                    if (!imem_ack) begin
                        squash_addr_d = fetch_pc_q;
                        state_d       = S_SQUASH;
                    end
                end else if (imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    // Keep fetching only if the queue still has room after this edge.
                    state_d    = (pop || (count_q < CW'(DEPTH - 1))) ? S_REQ : S_IDLE;
                end
            end
            S_SQUASH: begin
                if (imem_ack) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= {RESET_PC[31:2], 2'b00};
            squash_addr_q <= 32'h0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            squash_addr_q <= squash_addr_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    // Entry storage needs no reset: outputs are gated by count.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_pc_q[tail_q]   <= fetch_pc_q;
            ent_inst_q[tail_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - self-checking bench for ifetch_queue
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic [2:0]  count;

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_inst    (dec_inst),
        .dec_pc      (dec_pc),
        .count       (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        logic        ack;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        int          cycles;
        logic        exp_req;
        int          exp_count;
    } seg_t;

    ent_t        q[$];
    logic [31:0] m_pc = 32'h0;
    logic        m_sq = 1'b0;
    logic [31:0] m_sqaddr = 32'h0;
    int          checks = 0;
    int          errors = 0;
    logic        last_req;
    int          last_count;
    seg_t        segs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, compare outputs against the scoreboard, then
    // advance the scoreboard to what the coming edge must do.
    task automatic step(input logic a, input logic r, input logic rd, input logic [31:0] rp);
        logic exp_valid;
        ent_t hd;
        @(negedge clk);
        imem_ack    = a;
        dec_ready   = r;
        redirect    = rd;
        redirect_pc = rp;
        #1;
        last_req   = imem_req;
        last_count = int'(count);
        exp_valid  = (q.size() != 0) && !rd;
        chk("dec_valid", 32'(dec_valid), 32'(exp_valid));
        chk("count", 32'(count), 32'(q.size()));
        if (exp_valid) begin
            hd = q[0];
            chk("dec_pc", dec_pc, hd.pc);
            chk("dec_inst", dec_inst, hd.inst);
        end else if (q.size() == 0) begin
            chk("dec_pc_empty", dec_pc, 32'h0);
            chk("dec_inst_empty", dec_inst, 32'h0);
        end
        if (imem_req) begin
            chk("imem_addr", imem_addr, m_sq ? m_sqaddr : m_pc);
        end
        if (exp_valid && r) begin
            void'(q.pop_front());
        end
        if (rd) begin
            q.delete();
            if (imem_req && !a) begin
                if (!m_sq) m_sqaddr = m_pc;
                m_sq = 1'b1;
            end else if (imem_req && a) begin
                m_sq = 1'b0;
            end
            m_pc = {rp[31:2], 2'b00};
        end else if (imem_req && a) begin
            if (m_sq) begin
                m_sq = 1'b0;
            end else begin
                q.push_back('{pc: m_pc, inst: mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        //          ack   ready redir rpc           cyc req  count
        segs[0] = '{1'b1, 1'b0, 1'b0, 32'h0,         1, 1'b1, 0};
        segs[1] = '{1'b1, 1'b0, 1'b0, 32'h0,         5, 1'b0, 4};
        segs[2] = '{1'b1, 1'b1, 1'b0, 32'h0,         5, 1'b1, 2};
        segs[3] = '{1'b1, 1'b1, 1'b0, 32'h0,         3, 1'b1, 2};
        segs[4] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1, 1'b1, 2};
        segs[5] = '{1'b1, 1'b1, 1'b0, 32'h0,         4, 1'b1, 1};
        segs[6] = '{1'b0, 1'b1, 1'b0, 32'h0,         2, 1'b1, 0};
        segs[7] = '{1'b1, 1'b0, 1'b1, 32'h0000_0040, 1, 1'b1, 0};
        segs[8] = '{1'b0, 1'b0, 1'b0, 32'h0,         1, 1'b1, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_dec_valid", 32'(dec_valid), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_dec_pc", dec_pc, 32'h0);
        chk("rst_dec_inst", dec_inst, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            for (int c = 0; c < segs[i].cycles; c++) begin
                step(segs[i].ack, segs[i].ready, segs[i].redir, segs[i].rpc);
            end
            chk($sformatf("seg%0d_req", i), 32'(last_req), 32'(segs[i].exp_req));
            chk($sformatf("seg%0d_count", i), 32'(last_count), 32'(segs[i].exp_count));
        end
        chk("redir_ack_addr", imem_addr, 32'h0000_0040);

        // Redirect while the request is unacknowledged: squash the old word.
        step(1'b0, 1'b1, 1'b1, 32'h0000_0103);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("squash_req", 32'(imem_req), 32'h1);
        chk("squash_addr", imem_addr, 32'h0000_0040);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("post_squash_addr", imem_addr, 32'h0000_0100);
        chk("post_squash_valid", 32'(dec_valid), 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("target_valid", 32'(dec_valid), 32'h1);
        chk("target_pc", dec_pc, 32'h0000_0100);

        // Second redirect while already squashing only moves the target.
        step(1'b0, 1'b1, 1'b1, 32'h0000_0300);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0500);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("resquash_addr", imem_addr, 32'h0000_0500);
        chk("resquash_count", 32'(count), 32'h0);

        // Reset with three entries queued and a request pending.
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("pre_rst_count", 32'(count), 32'h3);
        chk("pre_rst_req", 32'(imem_req), 32'h1);
        rst = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 32'h0);
        chk("async_rst_valid", 32'(dec_valid), 32'h0);
        chk("async_rst_req", 32'(imem_req), 32'h0);
        chk("async_rst_pc", dec_pc, 32'h0);
        imem_ack = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        m_pc = 32'h0;
        m_sq = 1'b0;
        chk("released_idle", 32'(imem_req), 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("restart_req", 32'(imem_req), 32'h1);
        chk("restart_addr", imem_addr, 32'h0000_0000);
        chk("stray_ack_count", 32'(count), 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, instruction queue entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  word-aligned fetch address; bits [1:0] always 0.
REQ-007 imem_ack  input  1  read complete; imem_rdata valid this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 redirect  input  1  branch/jump taken; flush and refetch.
REQ-010 redirect_pc  input  32  new fetch address; bits [1:0] ignored.
REQ-011 dec_valid  output  1  head entry available to decode.
REQ-012 dec_ready  input  1  decode accepts head entry.
REQ-013 dec_inst  output  32  head instruction word.
REQ-014 dec_pc  output  32  address of head instruction.
REQ-015 count  output  clog2(DEPTH)+1  current queue occupancy.

Function
REQ-016 FSM states IDLE, REQ, SQUASH; state register, fetch_pc and queue are the only sequential state.
REQ-017 IDLE: imem_req=0; go to REQ next cycle when count < DEPTH.
REQ-018 REQ: imem_req=1, imem_addr=fetch_pc held stable until imem_ack sampled high.
REQ-019 On REQ edge with imem_ack=1 and redirect=0: push {fetch_pc, imem_rdata}; fetch_pc += 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); stay in REQ if post-push/post-pop occupancy < DEPTH, else IDLE.
REQ-020 One outstanding request maximum; back-to-back requests allowed (one per ack cycle).
REQ-021 dec_valid = (count != 0) && !redirect; dec_inst/dec_pc = head entry, X-free (0 when empty).
REQ-022 Pop on edge where dec_valid && dec_ready; same-cycle push and pop leave count unchanged.
REQ-023 Push never occurs when full; occupancy check in REQ-019 guarantees it.
REQ-024 Redirect edge: queue cleared (count=0), fetch_pc = {redirect_pc[31:2],2'b00}; pop suppressed.
REQ-025 Redirect in REQ with imem_ack=1 same edge: returned word discarded, next state REQ at new fetch_pc.
REQ-026 Redirect in REQ with imem_ack=0: next state SQUASH; request stays asserted at old address until ack; that word discarded; then REQ at new fetch_pc.
REQ-027 Redirect in SQUASH: updates fetch_pc only; remains SQUASH until ack.
REQ-028 Redirect in IDLE: next state REQ at new fetch_pc.
REQ-029 Minimum latency: ack edge -> dec_valid next cycle; redirect edge -> imem_req for new target same next cycle (except SQUASH).

Reset
REQ-030 rst low asynchronously forces: state IDLE, fetch_pc=RESET_PC, count=0, imem_req=0, dec_valid=0, dec_inst=0, dec_pc=0, head/tail pointers 0.
REQ-031 First edge after rst released: state REQ, imem_addr=RESET_PC.
REQ-032 rst asserted mid-request abandons it; any later stray imem_ack while IDLE is ignored.

Verification
REQ-033 Reset release, imem_ack always 1, dec_ready=1 -> dec_pc sequence 0,4,8,... one per cycle, dec_inst matches memory.
REQ-034 dec_ready=0, ack always 1, DEPTH=4 -> count reaches 4, imem_req drops, no overwrite; dec_ready=1 -> entries 0,4,8,12 drain in order, fetch resumes at 16.
REQ-035 Redirect to 32'h0000_0103 with imem_ack=0 in REQ -> SQUASH, old word discarded on ack, next imem_addr=32'h0000_0100, dec_valid=0 until that word returns.
REQ-036 Redirect and imem_ack same edge -> word discarded, count=0, imem_addr=redirect target next cycle.
REQ-037 Redirect to 32'hFFFF_FFFC, ack always 1 -> dec_pc FFFF_FFFC then 0000_0000.
REQ-038 rst pulsed low with 3 entries queued and request pending -> count=0, dec_valid=0 immediately; after release imem_addr=RESET_PC.
